// File: rtl/sec_timer_bank.sv
// -----------------------------------------------------------------------------
// sec_timer_bank
//
// Bank of CH independent down-counting timers sharing one internally generated
// time-base tick (CLK_HZ/TICK_HZ clock cycles per tick). Each channel supports
// load, start/resume, pause, and one-shot or periodic auto-reload. It reports
// the remaining count, a running flag, an expired level and a single-cycle
// done pulse on every expiry.
//
// Ports:
//   clock       in   1         system clock, all state changes on posedge
//   reset       in   1         asynchronous, active-low reset
//   load        in   CH        per-channel load strobe (highest priority)
//   load_value  in   CH*CNT_W  per-channel load value, ch i at [i*CNT_W +: CNT_W]
//   start       in   CH        per-channel start/resume strobe
//   stop        in   CH        per-channel pause strobe
//   periodic    in   CH        per-channel mode: 1 = auto-reload, 0 = one-shot
//   remaining   out  CH*CNT_W  current count per channel
//   running     out  CH        channel is counting
//   expired     out  CH        one-shot channel has reached 0
//   done        out  CH        one-cycle pulse on every expiry
//   tick        out  1         one-cycle time-base pulse
// -----------------------------------------------------------------------------
module sec_timer_bank #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int CH      = 4,
    parameter int CNT_W   = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CH-1:0]       load,
    input  logic [CH*CNT_W-1:0] load_value,
    input  logic [CH-1:0]       start,
    input  logic [CH-1:0]       stop,
    input  logic [CH-1:0]       periodic,
    output logic [CH*CNT_W-1:0] remaining,
    output logic [CH-1:0]       running,
    output logic [CH-1:0]       expired,
    output logic [CH-1:0]       done,
    output logic                tick
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Prescaler: free-running 0..DIV-1. tick is registered from the *next*
    // counter value so that it is high exactly while the counter sits at
    // DIV-1. With DIV=1 the counter stays at 0 and tick is high every cycle.
    // -------------------------------------------------------------------------
    logic [PS_W-1:0] ps_cnt;
    logic [PS_W-1:0] ps_nxt;

    always_comb begin
        ps_nxt = (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else begin
            ps_cnt <= ps_nxt;
            tick   <= (ps_nxt == PS_LAST);
        end
    end

    // -------------------------------------------------------------------------
    // Channel state
    // -------------------------------------------------------------------------
    logic [1:0]       state_q  [CH];
    logic [1:0]       state_d  [CH];
    logic [CNT_W-1:0] reload_q [CH];
    logic [CNT_W-1:0] reload_d [CH];
    logic [CNT_W-1:0] rem_q    [CH];
    logic [CNT_W-1:0] rem_d    [CH];
    logic [CH-1:0]    done_d;

    // Command priority per channel: load > stop > start > tick. A stop outside
    // RUN or a start inside RUN has no effect, so it falls through to the next
    // lower-priority command instead of swallowing the cycle.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            // NOTE: every combinational output gets a default first so no
            // path leaves it unassigned, which would infer a latch.
            state_d[i]  = state_q[i];
            reload_d[i] = reload_q[i];
            rem_d[i]    = rem_q[i];
            done_d[i]   = 1'b0;

            if (load[i]) begin
                reload_d[i] = load_value[i*CNT_W +: CNT_W];
                rem_d[i]    = load_value[i*CNT_W +: CNT_W];
                state_d[i]  = ST_IDLE;
            end else if (stop[i] && state_q[i] == ST_RUN) begin
                state_d[i] = ST_PAUSED;
            end else if (start[i] && state_q[i] != ST_RUN) begin
                case (state_q[i])
                    ST_IDLE, ST_PAUSED: begin
                        if (rem_q[i] != '0) state_d[i] = ST_RUN;
                    end
                    ST_EXPIRED: begin
                        if (reload_q[i] != '0) begin
                            rem_d[i]   = reload_q[i];
                            state_d[i] = ST_RUN;
                        end
                    end
                    default: ;
                endcase
            end else if (tick && state_q[i] == ST_RUN) begin
                if (rem_q[i] > CNT_ONE) begin
                    rem_d[i] = rem_q[i] - CNT_ONE;
                end else if (rem_q[i] == CNT_ONE) begin
                    done_d[i] = 1'b1;
                    if (periodic[i]) begin
                        rem_d[i] = reload_q[i];
                    end else begin
                        rem_d[i]   = '0;
                        state_d[i] = ST_EXPIRED;
                    end
                end
                // remaining==0 in RUN cannot be reached; it is simply held.
            end
        end
    end

    // running/expired are registered alongside the state so every output
    // comes straight from a flop.
    // NOTE: the per-channel reload registers are reset too, because a start
    // from EXPIRED reads reload and must see a defined 0 after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]  <= ST_IDLE;
                reload_q[i] <= '0;
                rem_q[i]    <= '0;
            end
            running <= '0;
            expired <= '0;
            done    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]  <= state_d[i];
                reload_q[i] <= reload_d[i];
                rem_q[i]    <= rem_d[i];
                running[i]  <= (state_d[i] == ST_RUN);
                expired[i]  <= (state_d[i] == ST_EXPIRED);
            end
            done <= done_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_rem_out
        assign remaining[g*CNT_W +: CNT_W] = rem_q[g];
    end

endmodule

// File: tb/tb_sec_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_sec_timer_bank
//
// Directed self-checking bench for sec_timer_bank with CLK_HZ=10, TICK_HZ=1
// (10 clocks per tick), CH=4, CNT_W=9. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sec_timer_bank;

    localparam int CH    = 4;
    localparam int CNT_W = 9;

    logic                clock;
    logic                reset;
    logic [CH-1:0]       load;
    logic [CH*CNT_W-1:0] load_value;
    logic [CH-1:0]       start;
    logic [CH-1:0]       stop;
    logic [CH-1:0]       periodic;
    logic [CH*CNT_W-1:0] remaining;
    logic [CH-1:0]       running;
    logic [CH-1:0]       expired;
    logic [CH-1:0]       done;
    logic                tick;

    logic [CNT_W-1:0] rem0, rem1, rem2, rem3;
    assign rem0 = remaining[0*CNT_W +: CNT_W];
    assign rem1 = remaining[1*CNT_W +: CNT_W];
    assign rem2 = remaining[2*CNT_W +: CNT_W];
    assign rem3 = remaining[3*CNT_W +: CNT_W];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sec_timer_bank #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .CH     (CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .remaining (remaining),
        .running   (running),
        .expired   (expired),
        .done      (done),
        .tick      (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Advance to a falling edge where tick is high; the next rising edge is
    // then a tick edge.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick=%b required 1 within 20 cycles", tick);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        load       = '0;
        load_value = '0;
        start      = '0;
        stop       = '0;
        periodic   = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({remaining, running, expired, done, tick} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rem=%h run=%b exp=%b done=%b tick=%b required all 0",
                     remaining, running, expired, done, tick);
        end
    endtask

    task automatic test_prescaler();
        reset = 1'b1;  // released on a falling edge: this is cycle 0
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL prescaler_c0: tick=%b required 0", tick);
        end
        for (int k = 1; k < 30; k++) begin
            step();
            checks++;
            if (tick !== ((k % 10) == 9)) begin
                errors++;
                $display("FAIL prescaler_c%0d: tick=%b required %b", k, tick, ((k % 10) == 9));
            end
        end
    endtask

    task automatic test_oneshot();
        int exp_vals[3] = '{2, 1, 0};
        load[0] = 1'b1;
        load_value[0*CNT_W +: CNT_W] = 9'd3;
        step();
        load[0] = 1'b0;
        checks++;
        if (rem0 !== 9'd3 || running[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_load: rem=%0d run=%b required 3 0", rem0, running[0]);
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++;
        if (running[0] !== 1'b1 || rem0 !== 9'd3) begin
            errors++;
            $display("FAIL oneshot_start: run=%b rem=%0d required 1 3", running[0], rem0);
        end
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            step();
            checks++;
            if (rem0 !== 9'(exp_vals[t]) || done[0] !== (exp_vals[t] == 0)) begin
                errors++;
                $display("FAIL oneshot_tick%0d: rem=%0d done=%b required %0d %b",
                         t, rem0, done[0], exp_vals[t], (exp_vals[t] == 0));
            end
        end
        checks++;
        if (expired[0] !== 1'b1 || running[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_expired: exp=%b run=%b required 1 0", expired[0], running[0]);
        end
        step();
        checks++;
        if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done_width: done=%b required 0", done[0]);
        end
        wait_tick();
        step();
        checks++;
        if (rem0 !== 9'd0 || expired[0] !== 1'b1 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold: rem=%0d exp=%b done=%b required 0 1 0",
                     rem0, expired[0], done[0]);
        end
    endtask

    task automatic test_periodic();
        int exp_vals[6] = '{1, 2, 1, 2, 1, 2};
        int last_done = -1;
        periodic[1] = 1'b1;
        load[1] = 1'b1;
        load_value[1*CNT_W +: CNT_W] = 9'd2;
        step();
        load[1] = 1'b0;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            wait_tick();
            step();
            checks++;
            if (rem1 !== 9'(exp_vals[t]) || done[1] !== (exp_vals[t] == 2) || expired[1] !== 1'b0) begin
                errors++;
                $display("FAIL periodic_tick%0d: rem=%0d done=%b exp=%b required %0d %b 0",
                         t, rem1, done[1], expired[1], exp_vals[t], (exp_vals[t] == 2));
            end
            if (done[1] === 1'b1) begin
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != 20) begin
                        errors++;
                        $display("FAIL periodic_gap: gap=%0d required 20", cyc - last_done);
                    end
                end
                last_done = cyc;
            end
        end
        checks++;
        if (running[1] !== 1'b1) begin
            errors++;
            $display("FAIL periodic_running: run=%b required 1", running[1]);
        end
    endtask

    task automatic test_pause_resume();
        int exp_vals[3] = '{2, 1, 0};
        load[2] = 1'b1;
        load_value[2*CNT_W +: CNT_W] = 9'd5;
        step();
        load[2] = 1'b0;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        repeat (2) begin
            wait_tick();
            step();
        end
        stop[2] = 1'b1;
        step();
        stop[2] = 1'b0;
        checks++;
        if (running[2] !== 1'b0 || rem2 !== 9'd3) begin
            errors++;
            $display("FAIL pause_stop: run=%b rem=%0d required 0 3", running[2], rem2);
        end
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            step();
            checks++;
            if (rem2 !== 9'd3) begin
                errors++;
                $display("FAIL pause_hold%0d: rem=%0d required 3", t, rem2);
            end
        end
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        checks++;
        if (running[2] !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: run=%b required 1", running[2]);
        end
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            step();
            checks++;
            if (rem2 !== 9'(exp_vals[t]) || done[2] !== (exp_vals[t] == 0)) begin
                errors++;
                $display("FAIL pause_run%0d: rem=%0d done=%b required %0d %b",
                         t, rem2, done[2], exp_vals[t], (exp_vals[t] == 0));
            end
        end
        checks++;
        if (expired[2] !== 1'b1) begin
            errors++;
            $display("FAIL pause_expired: exp=%b required 1", expired[2]);
        end
    endtask

    task automatic test_priority();
        load[3] = 1'b1;
        load_value[3*CNT_W +: CNT_W] = 9'd4;
        step();
        load[3] = 1'b0;
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        wait_tick();  // the next edge is a tick edge
        load[3] = 1'b1;
        stop[3] = 1'b1;
        start[3] = 1'b1;
        load_value[3*CNT_W +: CNT_W] = 9'd7;
        step();
        load[3] = 1'b0;
        stop[3] = 1'b0;
        start[3] = 1'b0;
        checks++;
        if (rem3 !== 9'd7 || running[3] !== 1'b0 || done[3] !== 1'b0) begin
            errors++;
            $display("FAIL priority_load: rem=%0d run=%b done=%b required 7 0 0",
                     rem3, running[3], done[3]);
        end
        // start with remaining=0 is ignored
        load[3] = 1'b1;
        load_value[3*CNT_W +: CNT_W] = 9'd0;
        step();
        load[3] = 1'b0;
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        checks++;
        if (running[3] !== 1'b0 || rem3 !== 9'd0 || expired[3] !== 1'b0) begin
            errors++;
            $display("FAIL priority_start_zero: run=%b rem=%0d exp=%b required 0 0 0",
                     running[3], rem3, expired[3]);
        end
        // maximum load value is accepted as-is
        load[3] = 1'b1;
        load_value[3*CNT_W +: CNT_W] = 9'h1FF;
        step();
        load[3] = 1'b0;
        checks++;
        if (rem3 !== 9'd511) begin
            errors++;
            $display("FAIL priority_max_load: rem=%0d required 511", rem3);
        end
    endtask

    task automatic test_reset_mid_run();
        // Two channels loaded and started in the same cycles.
        load[0] = 1'b1;
        load[1] = 1'b1;
        periodic[1] = 1'b0;
        load_value[0*CNT_W +: CNT_W] = 9'd3;
        load_value[1*CNT_W +: CNT_W] = 9'd6;
        step();
        load[0] = 1'b0;
        load[1] = 1'b0;
        start[0] = 1'b1;
        start[1] = 1'b1;
        step();
        start[0] = 1'b0;
        start[1] = 1'b0;
        wait_tick();
        step();
        checks++;
        if (rem0 !== 9'd2 || rem1 !== 9'd5 || running[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL multi_channel: rem0=%0d rem1=%0d run=%b required 2 5 11",
                     rem0, rem1, running[1:0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({remaining, running, expired, done, tick} !== '0) begin
            errors++;
            $display("FAIL async_reset: rem=%h run=%b exp=%b done=%b tick=%b required all 0",
                     remaining, running, expired, done, tick);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (tick !== (k == 9) || remaining !== '0) begin
                errors++;
                $display("FAIL post_reset_c%0d: tick=%b rem=%h required %b 0",
                         k, tick, remaining, (k == 9));
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_oneshot();
        test_periodic();
        test_pause_resume();
        test_priority();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
